// File: rtl/freq_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : freq_sweep_ctrl_if
//  Purpose  : Control/status bundle between the sweep controller and the
//             logic that programs it (sweep limits, dwell, start/stop, and
//             the registered frequency word plus status flags).
//  Revision : 1.0  initial release
// ============================================================================
interface freq_sweep_ctrl_if #(
  parameter int FREQ_W  = 24,
  parameter int DWELL_W = 16
);
  logic               start_in;
  logic               stop_in;
  logic [1:0]         mode_in;
  logic [FREQ_W-1:0]  f_start_in;
  logic [FREQ_W-1:0]  f_stop_in;
  logic [FREQ_W-1:0]  f_step_in;
  logic [DWELL_W-1:0] dwell_in;
  logic [FREQ_W-1:0]  freq_inc_out;
  logic               busy_out;
  logic               dir_out;
  logic               done_out;

  // Control side: programs the sweep and observes its progress
  modport master (
    output start_in, stop_in, mode_in, f_start_in, f_stop_in, f_step_in, dwell_in,
    input  freq_inc_out, busy_out, dir_out, done_out
  );

  // Sweep controller side
  modport slave (
    input  start_in, stop_in, mode_in, f_start_in, f_stop_in, f_step_in, dwell_in,
    output freq_inc_out, busy_out, dir_out, done_out
  );
endinterface
`default_nettype wire

// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : freq_sweep_ctrl
//  Purpose  : Steps a DDS frequency-increment word from f_start to f_stop in
//             f_step increments, holding each value for a programmable dwell.
//             Modes: one-shot up, sawtooth repeat, triangle.
//  Revision : 1.0  initial release
// ============================================================================
module freq_sweep_ctrl #(
  parameter int FREQ_W  = 24,
  parameter int DWELL_W = 16
) (
  input  wire               clk_in,
  input  wire               rstn_in,
  freq_sweep_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [1:0] M_REPEAT   = 2'd1;
  localparam logic [1:0] M_TRIANGLE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         r_mode;
  logic [FREQ_W-1:0]  r_f_start;
  logic [FREQ_W-1:0]  r_f_stop;
  logic [FREQ_W-1:0]  r_f_step;
  logic [DWELL_W-1:0] r_reload;
  logic [DWELL_W-1:0] r_cnt;
  logic [FREQ_W-1:0]  r_freq;
  logic               r_busy;
  logic               r_dir;
  logic               r_done;

  logic [FREQ_W:0]    w_sum;
  logic [FREQ_W:0]    w_diff;
  logic [FREQ_W-1:0]  w_next_up;
  logic [FREQ_W-1:0]  w_next_dn;
  logic [DWELL_W-1:0] w_in_reload;
  logic               w_degenerate;
  logic               w_go;

  // Next up/down candidates computed one bit wider so carry/borrow can clamp.
  // In UP-at-f_stop the down candidate is f_stop-step; in DOWN-at-f_start the
  // up candidate is f_start+step, so both transitions share these paths.
  always_comb begin
    w_sum     = {1'b0, r_freq} + {1'b0, r_f_step};
    w_diff    = {1'b0, r_freq} - {1'b0, r_f_step};
    w_next_up = (w_sum[FREQ_W] || (w_sum[FREQ_W-1:0] > r_f_stop))  ? r_f_stop  : w_sum[FREQ_W-1:0];
    w_next_dn = (w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] < r_f_start)) ? r_f_start : w_diff[FREQ_W-1:0];
  end

  // Start qualification and dwell reload (a dwell of 0 behaves like 1)
  always_comb begin
    w_go         = bus.start_in && !bus.stop_in;
    w_degenerate = (bus.f_step_in == '0) || (bus.f_stop_in <= bus.f_start_in);
    w_in_reload  = (bus.dwell_in == '0) ? '0 : bus.dwell_in - 1'b1;
  end

  // Sweep state machine, dwell counter and registered outputs
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_reload  <= '0;
      r_cnt     <= '0;
      r_freq    <= '0;
      r_busy    <= 1'b0;
      r_dir     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_mode    <= bus.mode_in;
            r_f_start <= bus.f_start_in;
            r_f_stop  <= bus.f_stop_in;
            r_f_step  <= bus.f_step_in;
            r_reload  <= w_in_reload;
            r_freq    <= bus.f_start_in;
            if (w_degenerate) begin
              r_done <= 1'b1;
            end else begin
              r_cnt   <= w_in_reload;
              r_busy  <= 1'b1;
              r_dir   <= 1'b1;
              r_state <= S_UP;
            end
          end
        end
        S_UP, S_DOWN: begin
          if (bus.stop_in) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt <= r_reload;
            if (r_state == S_UP) begin
              if (r_freq < r_f_stop) begin
                r_freq <= w_next_up;
              end else if (r_mode == M_REPEAT) begin
                r_freq <= r_f_start;
              end else if (r_mode == M_TRIANGLE) begin
                r_freq  <= w_next_dn;
                r_dir   <= 1'b0;
                r_state <= S_DOWN;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              if (r_freq > r_f_start) begin
                r_freq <= w_next_dn;
              end else begin
                r_freq  <= w_next_up;
                r_dir   <= 1'b1;
                r_state <= S_UP;
              end
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.freq_inc_out = r_freq;
  assign bus.busy_out     = r_busy;
  assign bus.dir_out      = r_dir;
  assign bus.done_out     = r_done;

endmodule
`default_nettype wire
